// File: rtl/io_compressor_tx.sv
// Run-length encoder for one row: emits alternating-polarity run codes (zeros first)
// over a valid/ready section bus, one code per cycle when the sink keeps up.
module io_compressor_tx #(
  parameter int unsigned sectionSize = 4,
  parameter int unsigned rowSize     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [rowSize-1:0]     row_in,
  input  logic                   row_valid,
  output logic                   row_ready,
  output logic [sectionSize-1:0] section_out,
  output logic                   section_valid,
  input  logic                   section_ready,
  output logic                   section_last,
  output logic                   done,
  output logic                   busy
);

  localparam int unsigned Pw     = $clog2(rowSize + 1);
  localparam int unsigned MaxRun = (1 << sectionSize) - 1;

  typedef enum logic [1:0] {StIdle, StEmit, StDone} state_e;

  state_e                   state_q, state_d;
  logic [rowSize-1:0]       row_q, row_d;
  logic [Pw-1:0]            pos_q, pos_d;
  logic                     cur_q, cur_d;
  logic [sectionSize-1:0]   section_q, section_d;
  logic                     last_q, last_d;

  // Length of the run of 'cur' starting at bit 0, capped at MaxRun and at 'remain'.
  function automatic logic [Pw-1:0] run_len(input logic [rowSize-1:0] bits, input logic cur,
                                            input logic [Pw-1:0] remain);
    logic [Pw-1:0] n;
    logic          go;
    n  = '0;
    go = 1'b1;
    for (int i = 0; i < int'(rowSize); i++) begin
      if (go && (bits[i] == cur) && (n < remain) && (32'(n) < MaxRun)) begin
        n = n + 1'b1;
      end else begin
        go = 1'b0;
      end
    end
    return n;
  endfunction

  logic [Pw-1:0]      cur_len;
  logic [Pw-1:0]      len;
  logic [Pw-1:0]      nxt_pos;
  logic [rowSize-1:0] nxt_row;

  // section_q never exceeds rowSize, so resizing to Pw is lossless.
  assign cur_len = Pw'(section_q);

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    pos_d     = pos_q;
    cur_d     = cur_q;
    section_d = section_q;
    last_d    = last_q;
    len       = '0;
    nxt_pos   = '0;
    nxt_row   = '0;
    unique case (state_q)
      StIdle: begin
        if (row_valid) begin
          len       = run_len(row_in, 1'b0, Pw'(rowSize));
          row_d     = row_in;
          pos_d     = '0;
          cur_d     = 1'b0;
          section_d = sectionSize'(len);
          last_d    = (len == Pw'(rowSize));
          state_d   = StEmit;
        end
      end
      StEmit: begin
        if (section_ready) begin
          if (last_q) begin
            state_d = StDone;
          end else begin
            // Load the following code in the handshake cycle so codes issue back-to-back.
            nxt_pos   = pos_q + cur_len;
            nxt_row   = row_q >> cur_len;
            len       = run_len(nxt_row, ~cur_q, Pw'(rowSize) - nxt_pos);
            row_d     = nxt_row;
            pos_d     = nxt_pos;
            cur_d     = ~cur_q;
            section_d = sectionSize'(len);
            last_d    = ((nxt_pos + len) == Pw'(rowSize));
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      row_q     <= '0;
      pos_q     <= '0;
      cur_q     <= 1'b0;
      section_q <= '0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      pos_q     <= pos_d;
      cur_q     <= cur_d;
      section_q <= section_d;
      last_q    <= last_d;
    end
  end

  assign row_ready     = (state_q == StIdle) && !rst;
  assign section_valid = (state_q == StEmit);
  assign section_out   = section_q;
  assign section_last  = last_q && (state_q == StEmit);
  assign done          = (state_q == StDone);
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_io_compressor_tx.sv
// Self-checking bench for io_compressor_tx: expected codes are queued per row and
// popped on every section handshake.
module tb_io_compressor_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] row_in;
  logic        row_valid;
  logic        row_ready;
  logic [3:0]  section_out;
  logic        section_valid;
  logic        section_ready;
  logic        section_last;
  logic        done;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  io_compressor_tx #(.sectionSize(4), .rowSize(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .row_in       (row_in),
    .row_valid    (row_valid),
    .row_ready    (row_ready),
    .section_out  (section_out),
    .section_valid(section_valid),
    .section_ready(section_ready),
    .section_last (section_last),
    .done         (done),
    .busy         (busy)
  );

  function automatic void push(input int code, input bit last);
    exp_q.push_back({last, 4'(code)});
  endfunction

  // Reference encoder walking the row bit by bit.
  function automatic void push_model(input logic [15:0] row);
    int pos = 0;
    bit cur = 1'b0;
    while (pos < 16) begin
      int n = 0;
      while ((pos + n) < 16 && row[pos+n] == cur && n < 15) n++;
      pos += n;
      push(n, pos == 16);
      cur = ~cur;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one row, drain its codes against exp_q, then check done/row_ready timing.
  // mode 0: ready always high, 1: pattern 1,0,0, 2: random.
  task automatic run_row(input logic [15:0] row, input int mode, input bit noisy, input int ncodes);
    int cyc = 0;
    int hs = 0;
    bit fin = 1'b0;
    bit stalled = 1'b0;
    logic [4:0] held = '0;
    logic [4:0] exp;
    checks++;
    if (row_ready !== 1'b1) begin
      errors++; $display("FAIL row_ready_idle got %b want 1", row_ready);
    end
    row_in = row;
    row_valid = 1'b1;
    step();
    if (noisy) row_in = ~row;
    else row_valid = 1'b0;
    checks++;
    if (section_valid !== 1'b1) begin
      errors++; $display("FAIL first_valid_latency got %b want 1", section_valid);
    end
    while (!fin && cyc < 200) begin
      case (mode)
        0: section_ready = 1'b1;
        1: section_ready = (cyc % 3 == 0);
        default: section_ready = 1'($urandom_range(0, 1));
      endcase
      checks++;
      if (section_valid !== 1'b1 || row_ready !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL emit_flags valid=%b row_ready=%b busy=%b want 1 0 1",
                           section_valid, row_ready, busy);
      end
      if (stalled) begin
        checks++;
        if ({section_last, section_out} !== held) begin
          errors++; $display("FAIL stall_hold got %h want %h", {section_last, section_out}, held);
        end
      end
      if (section_valid && section_ready) begin
        if (exp_q.size() == 0) exp = 5'h1f;
        else exp = exp_q.pop_front();
        checks++;
        if ({section_last, section_out} !== exp) begin
          errors++; $display("FAIL code[%0d] last/code got %b/%0d want %b/%0d",
                             hs, section_last, section_out, exp[4], exp[3:0]);
        end
        hs++;
        if (section_last === 1'b1) fin = 1'b1;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held = {section_last, section_out};
      end
      step();
      cyc++;
    end
    section_ready = 1'b0;
    checks++;
    if (!fin || hs != ncodes) begin
      errors++; $display("FAIL code_count got %0d (fin=%b) want %0d", hs, fin, ncodes);
    end
    if (mode == 0) begin
      checks++;
      if (cyc != ncodes) begin
        errors++; $display("FAIL back_to_back cycles got %0d want %0d", cyc, ncodes);
      end
    end
    checks++;
    if (done !== 1'b1 || section_valid !== 1'b0 || row_ready !== 1'b0) begin
      errors++; $display("FAIL done_pulse done=%b valid=%b row_ready=%b want 1 0 0",
                         done, section_valid, row_ready);
    end
    row_valid = 1'b0;
    exp_q.delete();
    step();
    checks++;
    if (done !== 1'b0 || row_ready !== 1'b1 || busy !== 1'b0 || section_valid !== 1'b0) begin
      errors++; $display("FAIL back_to_idle done=%b row_ready=%b busy=%b valid=%b want 0 1 0 0",
                         done, row_ready, busy, section_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; row_valid = 1'b0; row_in = '0; section_ready = 1'b0;
    step();
    step();
    checks++;
    if ({row_ready, section_valid, section_last, done, busy, section_out} !== 9'h0) begin
      errors++; $display("FAIL reset_outputs got %b want 0", {row_ready, section_valid,
                         section_last, done, busy, section_out});
    end
    rst = 1'b0;
    step();
    checks++;
    if (row_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL after_reset row_ready=%b busy=%b want 1 0", row_ready, busy);
    end
  endtask

  task automatic test_plan_rows();
    push(0, 0); push(8, 0); push(8, 1);
    run_row(16'h00ff, 0, 1'b0, 3);
    push(15, 0); push(0, 0); push(1, 1);
    run_row(16'h0000, 0, 1'b0, 3);
    push(0, 0); push(15, 0); push(0, 0); push(1, 1);
    run_row(16'hffff, 0, 1'b0, 4);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) push(1, i == 15);
    run_row(16'haaaa, 0, 1'b0, 16);
  endtask

  task automatic test_stall_and_ignore();
    // Bit 0 of 0x0F0F is 1, so a zero-length run of 0s leads.
    push(0, 0); push(4, 0); push(4, 0); push(4, 0); push(4, 1);
    run_row(16'h0f0f, 1, 1'b1, 5);
  endtask

  task automatic test_reset_mid_row();
    int hs = 0;
    row_in = 16'haaaa; row_valid = 1'b1;
    step();
    row_valid = 1'b0;
    section_ready = 1'b1;
    for (int c = 0; c < 10 && hs < 2; c++) begin
      checks++;
      if (section_valid !== 1'b1 || section_out !== 4'd1) begin
        errors++; $display("FAIL pre_reset_code valid=%b code=%0d want 1 1", section_valid,
                           section_out);
      end
      if (section_valid) hs++;
      step();
    end
    rst = 1'b1;
    section_ready = 1'b0;
    step();
    checks++;
    if ({row_ready, section_valid, section_last, done, busy, section_out} !== 9'h0) begin
      errors++; $display("FAIL mid_row_reset got %b want 0", {row_ready, section_valid,
                         section_last, done, busy, section_out});
    end
    rst = 1'b0;
    step();
    checks++;
    if (row_ready !== 1'b1 || section_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle row_ready=%b valid=%b want 1 0", row_ready,
                         section_valid);
    end
    push(0, 0); push(8, 0); push(8, 1);
    run_row(16'h00ff, 0, 1'b0, 3);
  endtask

  task automatic test_random_rows();
    for (int i = 0; i < 6; i++) begin
      logic [15:0] r;
      r = 16'($urandom);
      push_model(r);
      run_row(r, 2, 1'b0, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_plan_rows();
    test_back_to_back();
    test_stall_and_ignore();
    test_reset_mid_row();
    test_random_rows();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
